// File: rtl/st7735_spi_reader.sv
// ST7735 3-wire SPI read engine: sends one 8-bit read command, turns SDA
// around, optionally clocks one dummy bit, then shifts in up to 32 response
// bits MSB-first. All pin outputs are registered.
module st7735_spi_reader #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic        dummy,
  input  logic [5:0]  rd_bits,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        lcd_cs_n,
  output logic        lcd_dc,
  output logic        lcd_sclk,
  output logic        sda_out,
  output logic        sda_oe,
  input  logic        sda_in
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_CMD,
    S_DUMMY,
    S_READ,
    S_CS_HOLD,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [5:0]    bit_q,   bit_d;
  logic [6:0]    tx_q,    tx_d;
  logic [5:0]    len_q,   len_d;
  logic          dum_q,   dum_d;
  logic [31:0]   sh_q,    sh_d;

  logic          cs_n_q,  cs_n_d;
  logic          dc_q,    dc_d;
  logic          sclk_q,  sclk_d;
  logic          sdo_q,   sdo_d;
  logic          oe_q,    oe_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          phase_end;

  assign phase_end = (cnt_q == LAST);

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign lcd_cs_n = cs_n_q;
  assign lcd_dc   = dc_q;
  assign lcd_sclk = sclk_q;
  assign sda_out  = sdo_q;
  assign sda_oe   = oe_q;

  // State, counters and registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      len_q   <= '0;
      dum_q   <= 1'b0;
      sh_q    <= '0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b1;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      len_q   <= len_d;
      dum_q   <= dum_d;
      sh_q    <= sh_d;
      cs_n_q  <= cs_n_d;
      dc_q    <= dc_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and next-output logic; sclk toggles only at phase ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    len_d   = len_q;
    dum_d   = dum_q;
    sh_d    = sh_q;
    cs_n_d  = cs_n_q;
    dc_d    = dc_q;
    sclk_d  = sclk_q;
    sdo_d   = sdo_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;

    if (state_q != S_IDLE && state_q != S_DONE) begin
      cnt_d = phase_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CS_SETUP;
          cnt_d   = '0;
          tx_d    = cmd[6:0];
          len_d   = (rd_bits > 6'd32) ? 6'd32 : rd_bits;
          dum_d   = dummy && (rd_bits != 6'd0);
          sh_d    = '0;
          cs_n_d  = 1'b0;
          dc_d    = 1'b0;
          sclk_d  = 1'b0;
          sdo_d   = cmd[7];
          oe_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_CS_SETUP: begin
        if (phase_end) begin
          state_d = S_CMD;
          bit_d   = 6'd7;
        end
      end

      S_CMD: begin
        if (phase_end) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q != 6'd0) begin
              bit_d = bit_q - 6'd1;
              sdo_d = tx_q[6];
              tx_d  = {tx_q[5:0], 1'b0};
            end else begin
              // Turnaround: release SDA and raise DC on the falling edge of bit 0.
              oe_d  = 1'b0;
              sdo_d = 1'b0;
              dc_d  = 1'b1;
              bit_d = len_q;
              if (len_q == 6'd0) begin
                state_d = S_CS_HOLD;
              end else if (dum_q) begin
                state_d = S_DUMMY;
              end else begin
                state_d = S_READ;
              end
            end
          end
        end
      end

      S_DUMMY: begin
        if (phase_end) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d  = 1'b0;
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        if (phase_end) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            sh_d   = {sh_q[30:0], sda_in};
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q - 6'd1;
            if (bit_q == 6'd1) begin
              state_d = S_CS_HOLD;
            end
          end
        end
      end

      S_CS_HOLD: begin
        if (phase_end) begin
          state_d = S_DONE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rdata_d = sh_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_st7735_spi_reader.sv
// Directed bench for st7735_spi_reader: one instance at CLK_DIV=2, one at
// CLK_DIV=1, each with a simple panel model driving SDA on sclk falls.
module tb_st7735_spi_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start   [2];
  logic [7:0]  cmd     [2];
  logic        dummy   [2];
  logic [5:0]  rd_bits [2];
  logic        busy    [2];
  logic        done    [2];
  logic [31:0] rdata   [2];
  logic        cs_n    [2];
  logic        dc      [2];
  logic        sclk    [2];
  logic        sdo     [2];
  logic        oe      [2];
  logic        sda_in  [2] = '{1'b0, 1'b0};

  st7735_spi_reader #(.CLK_DIV(2)) u_dut_div2 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .cmd(cmd[0]), .dummy(dummy[0]),
    .rd_bits(rd_bits[0]), .busy(busy[0]), .done(done[0]), .rdata(rdata[0]),
    .lcd_cs_n(cs_n[0]), .lcd_dc(dc[0]), .lcd_sclk(sclk[0]), .sda_out(sdo[0]),
    .sda_oe(oe[0]), .sda_in(sda_in[0])
  );

  st7735_spi_reader #(.CLK_DIV(1)) u_dut_div1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .cmd(cmd[1]), .dummy(dummy[1]),
    .rd_bits(rd_bits[1]), .busy(busy[1]), .done(done[1]), .rdata(rdata[1]),
    .lcd_cs_n(cs_n[1]), .lcd_dc(dc[1]), .lcd_sclk(sclk[1]), .sda_out(sdo[1]),
    .sda_oe(oe[1]), .sda_in(sda_in[1])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Free-running monitor counters (only this block writes them).
  int         busy_cyc  [2] = '{0, 0};
  int         done_cnt  [2] = '{0, 0};
  int         rise_cnt  [2] = '{0, 0};
  int         fall_cnt  [2] = '{0, 0};
  int         dclow_cyc [2] = '{0, 0};
  int         oe_bad    [2] = '{0, 0};
  int         cs_hi_run [2] = '{0, 0};
  int         cs_gap    [2] = '{0, 0};
  logic [7:0] cap_cmd   [2] = '{8'h00, 8'h00};
  logic       prev_sclk [2] = '{1'b0, 1'b0};
  logic       prev_cs   [2] = '{1'b1, 1'b1};

  // Panel model settings (written by the stimulus, read by the monitor).
  logic [31:0] pdata     [2] = '{32'h0, 32'h0};
  int          plen      [2] = '{0, 0};
  int          pfirst    [2] = '{8, 8};
  int          fall_base [2] = '{0, 0};

  // Monitor and panel model: sample away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int n;
      if (busy[k]) busy_cyc[k]++;
      if (done[k]) done_cnt[k]++;
      if (!dc[k]) dclow_cyc[k]++;
      if (!cs_n[k] && dc[k] && oe[k]) oe_bad[k]++;
      if (sclk[k] && !prev_sclk[k]) begin
        rise_cnt[k]++;
        if (!dc[k]) cap_cmd[k] = {cap_cmd[k][6:0], sdo[k]};
      end
      if (!sclk[k] && prev_sclk[k]) begin
        fall_cnt[k]++;
        n = fall_cnt[k] - fall_base[k];
        if (n >= pfirst[k] && (n - pfirst[k]) < plen[k])
          sda_in[k] = pdata[k][plen[k] - 1 - (n - pfirst[k])];
      end
      if (cs_n[k]) begin
        cs_hi_run[k]++;
      end else begin
        if (prev_cs[k]) cs_gap[k] = cs_hi_run[k];
        cs_hi_run[k] = 0;
      end
      prev_sclk[k] = sclk[k];
      prev_cs[k]   = cs_n[k];
    end
  end

  int s_busy, s_done, s_rise, s_dclow, s_oe;
  logic [31:0] ref_word;
  logic [6:0]  ref_pins;

  task automatic launch(input int k, input logic [7:0] c, input logic d,
                        input logic [5:0] b, input logic [31:0] data);
    int r;
    @(negedge clk);
    r = (b > 6'd32) ? 32 : int'(b);
    pdata[k]     = data;
    plen[k]      = r;
    pfirst[k]    = (d && r != 0) ? 9 : 8;
    fall_base[k] = fall_cnt[k];
    s_busy  = busy_cyc[k];
    s_done  = done_cnt[k];
    s_rise  = rise_cnt[k];
    s_dclow = dclow_cyc[k];
    s_oe    = oe_bad[k];
    cmd[k]     = c;
    dummy[k]   = d;
    rd_bits[k] = b;
    start[k]   = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  // Returns at the negedge inside the DONE cycle; optional start poke mid-run.
  task automatic wait_done(input string lbl, input int k, input int limit, input int poke);
    logic got;
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      if (poke != 0 && i == poke) start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
      if (done[k]) got = 1'b1;
    end
    check_eq({lbl, "_done_seen"}, {31'b0, got}, 32'd1);
  endtask

  task automatic check_txn(input string lbl, input int k, input int exp_busy,
                           input int exp_rise, input int exp_dclow, input logic [7:0] exp_cmd);
    repeat (4) @(negedge clk);
    check_eq({lbl, "_busy_cycles"}, busy_cyc[k] - s_busy, exp_busy);
    check_eq({lbl, "_done_pulses"}, done_cnt[k] - s_done, 1);
    check_eq({lbl, "_sclk_rises"}, rise_cnt[k] - s_rise, exp_rise);
    check_eq({lbl, "_dc_low_cycles"}, dclow_cyc[k] - s_dclow, exp_dclow);
    check_eq({lbl, "_oe_after_turn"}, oe_bad[k] - s_oe, 0);
    check_eq({lbl, "_cmd_bits"}, {24'b0, cap_cmd[k]}, {24'b0, exp_cmd});
    check_eq({lbl, "_busy_idle"}, {31'b0, busy[k]}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; cmd[k] = 8'h00; dummy[k] = 1'b0; rd_bits[k] = 6'd0;
    end
    repeat (3) @(negedge clk);
    // cs_n, dc, sclk, sda_out, sda_oe, busy, done
    ref_pins = 7'b1100000;
    check_eq("reset_pins", {25'b0, cs_n[0], dc[0], sclk[0], sdo[0], oe[0], busy[0], done[0]},
             {25'b0, ref_pins});
    check_eq("reset_rdata", rdata[0], 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ID read with dummy clock, CLK_DIV=2: 2*(2+2*(8+1+24)) = 136
    launch(0, 8'h04, 1'b1, 6'd24, 32'h007C89F0);
    wait_done("t1", 0, 400, 0);
    check_eq("t1_rdata", rdata[0], 32'h007C89F0);
    check_eq("t1_busy_in_done", {31'b0, busy[0]}, 32'd0);
    check_txn("t1", 0, 136, 33, 34, 8'h04);

    // Status read, 32 bits, CLK_DIV=1: 1*(2+2*(8+1+32)) = 84
    launch(1, 8'h09, 1'b1, 6'd32, 32'hA5A50F0F);
    wait_done("t2", 1, 400, 0);
    ref_word = 32'hA5A50F0F;
    for (int i = 31; i >= 0; i--)
      check_eq($sformatf("t2_rdata_bit%0d", i), {31'b0, rdata[1][i]}, {31'b0, ref_word[i]});
    check_txn("t2", 1, 84, 41, 17, 8'h09);

    // Command-only: dummy ignored, 2*18 = 36
    launch(0, 8'h01, 1'b1, 6'd0, 32'hFFFFFFFF);
    wait_done("t3", 0, 400, 0);
    check_eq("t3_rdata", rdata[0], 32'h0);
    check_txn("t3", 0, 36, 8, 34, 8'h01);

    // rd_bits=40 clamps to 32; start poke while busy is ignored: 2*(2+2*40) = 164
    launch(0, 8'h0A, 1'b0, 6'd40, 32'h12345678);
    wait_done("t4", 0, 600, 20);
    check_eq("t4_rdata", rdata[0], 32'h12345678);
    check_txn("t4", 0, 164, 40, 34, 8'h0A);
    repeat (30) @(negedge clk);
    check_eq("t4_no_second_txn", busy_cyc[0] - s_busy, 164);

    // Async reset during READ (cycle 41 of busy; READ starts at 35)
    launch(0, 8'h04, 1'b0, 6'd16, 32'h0000BEEF);
    repeat (40) @(negedge clk);
    check_eq("t5_in_read", {30'b0, busy[0], dc[0]}, 32'd3);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_pins", {28'b0, cs_n[0], sclk[0], oe[0], busy[0]}, 32'b1000);
    check_eq("t5_rst_rdata", rdata[0], 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // Clean run after reset: 2*(2+2*(8+1+8)) = 72
    launch(0, 8'h09, 1'b1, 6'd8, 32'h0000005A);
    wait_done("t5b", 0, 400, 0);
    check_eq("t5b_rdata", rdata[0], 32'h0000005A);
    check_txn("t5b", 0, 72, 17, 34, 8'h09);

    // Back-to-back: second start in the IDLE cycle right after DONE
    launch(0, 8'h04, 1'b0, 6'd8, 32'h000000C3);
    wait_done("t6a", 0, 400, 0);
    check_eq("t6a_rdata", rdata[0], 32'h000000C3);
    check_eq("t6a_busy_cycles", busy_cyc[0] - s_busy, 2 * (2 + 2 * 16));
    launch(0, 8'h09, 1'b0, 6'd4, 32'h00000009);
    wait_done("t6b", 0, 400, 0);
    check_eq("t6b_rdata", rdata[0], 32'h00000009);
    check_eq("t6b_cs_gap", cs_gap[0], 2);
    check_txn("t6b", 0, 2 * (2 + 2 * 12), 12, 34, 8'h09);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
